// File: rtl/regfile_pkg.sv
// Shared defaults and the address-width helper for the multi-port register file.
package regfile_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int NUM_RD_DEF   = 2;

   // Never returns less than 1, so a two-entry file still gets a one-bit address.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Issue/writeback bus of the register file: read ports, write port, busy set and flush.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NUM_RD   = NUM_RD_DEF
);
   localparam int AW = clog2(NUM_REGS);

   logic                     rd_en;
   logic [NUM_RD*AW-1:0]     rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [AW-1:0]            wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     set_busy_en;
   logic [AW-1:0]            set_busy_addr;
   logic                     flush;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, set_busy_en, set_busy_addr, flush,
      input  rd_data, rd_busy
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, set_busy_en, set_busy_addr, flush,
      output rd_data, rd_busy
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: flush beats set, set beats writeback clear; r0 optionally never busy.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int R0_ZERO  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REGS-1:0] set_i,
   input  logic [NUM_REGS-1:0] clear_i,
   input  logic                flush_i,
   output logic [NUM_REGS-1:0] busy_o
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      if (flush_i) begin
         busy_d = '0;
      end else begin
         busy_d = (busy_q & ~clear_i) | set_i;
      end
      if (R0_ZERO != 0) busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, optional write bypass,
// optional hardwired-zero r0 and a busy scoreboard for issue/writeback.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NUM_RD   = NUM_RD_DEF,
   parameter int R0_ZERO  = 1,
   parameter int BYPASS   = 1
) (
   input logic          clk,
   input logic          rst_n,
   regfile_mp_if.slave  bus
);

   localparam int AW = clog2(NUM_REGS);

   logic [DATA_W-1:0]        regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]      set_vec;
   logic [NUM_REGS-1:0]      clr_vec;
   logic [NUM_REGS-1:0]      busy;
   logic                     wr_eff;
   logic [AW-1:0]            rd_a [NUM_RD];
   logic [NUM_RD*DATA_W-1:0] rd_data_d, rd_data_q;
   logic [NUM_RD-1:0]        rd_busy_d, rd_busy_q;

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (32'(a) < 32'(NUM_REGS)) && !((R0_ZERO != 0) && (a == '0));
   endfunction

   always_comb wr_eff = bus.wr_en && addr_ok(bus.wr_addr);

   // Out-of-range addresses never match any index, so the decode also filters them.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         if (wr_eff && (32'(bus.wr_addr) == r))            clr_vec[r] = 1'b1;
         if (bus.set_busy_en && (32'(bus.set_busy_addr) == r)) set_vec[r] = 1'b1;
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .R0_ZERO  (R0_ZERO)
   ) u_scoreboard (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_i   (set_vec),
      .clear_i (clr_vec),
      .flush_i (bus.flush),
      .busy_o  (busy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      end else if (wr_eff) begin
         regs_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_comb begin
      rd_data_d = '0;
      rd_busy_d = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         rd_a[p] = bus.rd_addr[p*AW +: AW];
         if (addr_ok(rd_a[p])) begin
            if ((BYPASS != 0) && wr_eff && (bus.wr_addr == rd_a[p])) begin
               rd_data_d[p*DATA_W +: DATA_W] = bus.wr_data;
               rd_busy_d[p]                  = 1'b0;
            end else begin
               rd_data_d[p*DATA_W +: DATA_W] = regs_q[rd_a[p]];
               rd_busy_d[p]                  = busy[rd_a[p]];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
         rd_busy_q <= '0;
      end else if (bus.rd_en) begin
         rd_data_q <= rd_data_d;
         rd_busy_q <= rd_busy_d;
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.rd_busy = rd_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Drives two register-file configurations with shared stimulus and checks them
// against an array-based reference model of the read/write/busy rules.
module tb_regfile_mp;

   localparam int AW = 5;
   localparam int NP = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            rd_en, wr_en, set_busy_en, flush;
   logic [NP*AW-1:0] rd_addr;
   logic [AW-1:0]   wr_addr, sb_addr;
   logic [31:0]     wr_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) bus0 ();
   regfile_mp_if #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(3)) bus1 ();

   assign bus0.rd_en = rd_en;          assign bus1.rd_en = rd_en;
   assign bus0.rd_addr = rd_addr[2*AW-1:0];
   assign bus1.rd_addr = rd_addr;
   assign bus0.wr_en = wr_en;          assign bus1.wr_en = wr_en;
   assign bus0.wr_addr = wr_addr;      assign bus1.wr_addr = wr_addr;
   assign bus0.wr_data = wr_data;      assign bus1.wr_data = wr_data;
   assign bus0.set_busy_en = set_busy_en;   assign bus1.set_busy_en = set_busy_en;
   assign bus0.set_busy_addr = sb_addr;     assign bus1.set_busy_addr = sb_addr;
   assign bus0.flush = flush;          assign bus1.flush = flush;

   regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .R0_ZERO(1), .BYPASS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));
   regfile_mp #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(3), .R0_ZERO(0), .BYPASS(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));

   // Reference model: one architectural state per configuration.
   int          cfg_n   [2] = '{32, 24};
   int          cfg_r0  [2] = '{1, 0};
   int          cfg_byp [2] = '{1, 0};
   int          cfg_nrd [2] = '{2, 3};
   logic [31:0] mregs [2][32];
   bit          mbusy [2][32];
   logic [31:0] exp_d [2][NP];
   bit          exp_b [2][NP];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] act_d(input int k, input int p);
      return (k == 0) ? bus0.rd_data[p*32 +: 32] : bus1.rd_data[p*32 +: 32];
   endfunction

   function automatic logic [31:0] act_b(input int k, input int p);
      return (k == 0) ? 32'(bus0.rd_busy[p]) : 32'(bus1.rd_busy[p]);
   endfunction

   function automatic bit mvalid(input int k, input int a);
      return (a < cfg_n[k]) && !(cfg_r0[k] != 0 && a == 0);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 32; r++) begin mregs[k][r] = '0; mbusy[k][r] = 0; end
         for (int p = 0; p < NP; p++) begin exp_d[k][p] = '0; exp_b[k][p] = 0; end
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         bit eff;
         int wa, sa;
         wa  = int'(wr_addr);
         sa  = int'(sb_addr);
         eff = wr_en && mvalid(k, wa);
         if (rd_en) begin
            for (int p = 0; p < cfg_nrd[k]; p++) begin
               int a;
               a = int'(rd_addr[p*AW +: AW]);
               if (!mvalid(k, a)) begin
                  exp_d[k][p] = '0;  exp_b[k][p] = 0;
               end else if (cfg_byp[k] != 0 && eff && wa == a) begin
                  exp_d[k][p] = wr_data;  exp_b[k][p] = 0;
               end else begin
                  exp_d[k][p] = mregs[k][a];  exp_b[k][p] = mbusy[k][a];
               end
            end
         end
         if (flush) begin
            for (int r = 0; r < 32; r++) mbusy[k][r] = 0;
         end else begin
            if (eff) mbusy[k][wa] = 0;
            if (set_busy_en && mvalid(k, sa)) mbusy[k][sa] = 1;
         end
         if (eff) mregs[k][wa] = wr_data;
      end
   endtask

   task automatic compare_all(input string tag);
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < cfg_nrd[k]; p++) begin
            check($sformatf("%s.dut%0d.data%0d", tag, k, p), act_d(k, p), exp_d[k][p]);
            check($sformatf("%s.dut%0d.busy%0d", tag, k, p), act_b(k, p), 32'(exp_b[k][p]));
         end
      end
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic idle();
      rd_en = 0; wr_en = 0; set_busy_en = 0; flush = 0;
   endtask

   task automatic set_rd(input int a0, input int a1, input int a2);
      rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
   endtask

   task automatic do_wr(input int a, input logic [31:0] d);
      wr_en = 1; wr_addr = AW'(a); wr_data = d;
   endtask

   initial begin
      idle();
      rd_addr = '0; wr_addr = '0; sb_addr = '0; wr_data = '0;
      model_reset();
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      compare_all("reset");

      // Async reset wipes data without any clock edge.
      do_wr(5, 32'hDEADBEEF); step("wr_r5");
      idle(); rd_en = 1; set_rd(5, 5, 5); step("rd_r5");
      check("r5_before_reset", act_d(0, 0), 32'hDEADBEEF);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_data", act_d(0, 0), 32'h0);
      check("arst_busy", act_b(0, 0), 32'h0);
      compare_all("arst");
      #1 rst_n = 1'b1;
      step("rd_r5_after_reset");
      check("r5_after_reset", act_d(0, 0), 32'h0);

      // Basic write/read and hold.
      idle(); do_wr(3, 32'h12345678); step("wr_r3");
      idle(); rd_en = 1; set_rd(3, 3, 3); step("rd_r3");
      check("r3_p0", act_d(0, 0), 32'h12345678);
      check("r3_p1", act_d(0, 1), 32'h12345678);
      rd_en = 0; set_rd(4, 4, 4); step("hold");
      check("hold_p0", act_d(0, 0), 32'h12345678);

      // Write-to-read bypass vs no bypass.
      idle(); do_wr(7, 32'h1); step("wr_r7");
      do_wr(7, 32'hA5A5A5A5); rd_en = 1; set_rd(7, 7, 7); step("byp_r7");
      check("byp_on", act_d(0, 0), 32'hA5A5A5A5);
      check("byp_off", act_d(1, 0), 32'h00000001);
      idle(); rd_en = 1; step("rd_r7");
      check("byp_off_next", act_d(1, 0), 32'hA5A5A5A5);

      // r0 hardwired zero and out-of-range addresses.
      idle(); do_wr(0, 32'hFFFFFFFF); step("wr_r0");
      idle(); rd_en = 1; set_rd(0, 0, 0); step("rd_r0");
      check("r0_zero", act_d(0, 0), 32'h0);
      idle(); do_wr(30, 32'hCAFEF00D); sb_addr = AW'(30); set_busy_en = 1; step("wr_r30");
      idle(); rd_en = 1; set_rd(30, 30, 30); step("rd_r30");
      check("oob_data", act_d(1, 0), 32'h0);
      check("oob_busy", act_b(1, 0), 32'h0);

      // Scoreboard set/clear/flush priorities.
      idle(); set_busy_en = 1; sb_addr = AW'(9); step("set_r9");
      idle(); rd_en = 1; set_rd(9, 9, 9); step("rd_r9");
      check("r9_busy", act_b(0, 0), 32'h1);
      idle(); do_wr(9, 32'h99); set_busy_en = 1; sb_addr = AW'(9); step("wr_set_r9");
      idle(); rd_en = 1; step("rd_r9_again");
      check("r9_set_wins", act_b(0, 0), 32'h1);
      idle(); do_wr(9, 32'h999); rd_en = 1; step("wr_rd_r9");
      check("r9_wb_clear", act_b(0, 0), 32'h0);
      idle(); set_busy_en = 1; sb_addr = AW'(2); flush = 1; step("set_flush_r2");
      idle(); rd_en = 1; set_rd(2, 2, 2); step("rd_r2");
      check("r2_flushed", act_b(0, 0), 32'h0);

      // Set, write and read of the same register in one cycle.
      idle(); set_busy_en = 1; sb_addr = AW'(4); do_wr(4, 32'h55); rd_en = 1; set_rd(4, 4, 4);
      step("sim_r4");
      check("sim_data", act_d(0, 0), 32'h55);
      check("sim_busy", act_b(0, 0), 32'h0);
      idle(); rd_en = 1; step("sim_r4_next");
      check("sim_busy_next", act_b(0, 0), 32'h1);

      // Randomized traffic, biased toward a few registers to provoke collisions.
      for (int i = 0; i < 800; i++) begin
         idle();
         rd_en       = ($urandom_range(0, 3) != 0);
         wr_en       = $urandom_range(0, 1);
         set_busy_en = ($urandom_range(0, 9) < 3);
         flush       = ($urandom_range(0, 19) == 0);
         wr_data     = $urandom;
         for (int p = 0; p < NP; p++)
            rd_addr[p*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         wr_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         sb_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         step($sformatf("rnd%0d", i));
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            #1 model_reset();
            compare_all("rnd_arst");
            #1 rst_n = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file with registered read outputs, optional write-to-read bypass, optional hardwired-zero register 0 and a per-register busy scoreboard.
- Sits between decode/issue and writeback in the CPU datapath.
- Read ports latch data and busy status on rd_en, so issue can stall without losing operands.
- Single write port from writeback; issue marks destinations busy; writeback clears them.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers (2..256, need not be a power of 2).
- NUM_RD, 2, number of read ports (1..4).
- R0_ZERO, 1, 1 = register 0 reads 0, ignores writes, never busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads.
- Localparam AW = clog2(NUM_REGS).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  capture enable for all read ports; low = outputs hold.
- rd_addr  in  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  registered read data; port i at [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  registered busy flag per read port.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  DATA_W  write data.
- set_busy_en  in  1  mark set_busy_addr busy (instruction issue).
- set_busy_addr  in  AW  destination register being issued.
- flush  in  1  clear all busy bits (pipeline flush).

Behaviour:
- Reset (async, rst_n=0): all registers = 0, all busy bits = 0, rd_data = 0, rd_busy = 0. Reset mid-write discards the write. No clock is needed for reset to take effect.
- Write: on the clk edge with wr_en=1, regs[wr_addr] <= wr_data.
  - Ignored if wr_addr >= NUM_REGS.
  - Ignored if R0_ZERO=1 and wr_addr = 0.
  - Writes are never blocked by rd_en or any other input.
- Read latency: 1 cycle. On the clk edge with rd_en=1, each port i captures rd_data[i] by priority:
  1. 0 if addr >= NUM_REGS, or if R0_ZERO and addr = 0.
  2. wr_data if BYPASS=1, the write is effective (not ignored) and wr_addr = addr.
  3. Otherwise regs[addr] as it was before this edge.
- Read hold: with rd_en=0, rd_data and rd_busy hold their values.
- Multiple ports may read the same address; each receives identical data and busy.
- Busy bits, per-register update priority each edge:
  1. flush=1: all bits clear, including any concurrent set.
  2. set_busy_en=1 and set_busy_addr = r: bit r set. If a write to r clears it in the same cycle, the set wins (new producer).
  3. Effective write to r: bit r cleared.
  - set_busy_addr >= NUM_REGS is ignored.
  - With R0_ZERO=1, register 0 is never busy.
- rd_busy[i], captured on rd_en=1:
  - BYPASS=1: busy[addr] before the edge, AND NOT (effective write to addr this cycle).
  - BYPASS=0: busy[addr] before the edge.
  - A same-cycle set_busy does not affect a same-cycle read.
  - Out-of-range addresses read as not busy.
- No combinational path from any input to any output.

Decomposition:
- Package regfile_pkg holds:
  - default constants DATA_W_DEF, NUM_REGS_DEF, NUM_RD_DEF;
  - the clog2 function used for AW.
- One sub-module, regfile_scoreboard, holds the busy bit vector, set/clear/flush priority and R0 masking. Parameters: NUM_REGS, R0_ZERO. Ports: set, clear, flush, and a NUM_REGS-wide busy vector output.
- Storage array and read muxing stay in regfile_mp.

Test Plan:
- Reset: write 0xDEADBEEF to r5, pulse rst_n low without a clock edge -> rd_data and rd_busy are 0 immediately; a later read of r5 returns 0x00000000.
- Basic read/write: write r3=0x12345678, then rd_en=1 with port0=r3, port1=r3 -> both ports show 0x12345678 one cycle later; with rd_en=0 and address changed to r4, outputs hold 0x12345678.
- Bypass: in one cycle write r7=0xA5A5A5A5 and read port0=r7 (r7 was 0x1) -> BYPASS=1 gives 0xA5A5A5A5; BYPASS=0 gives 0x00000001, then 0xA5A5A5A5 on the next read.
- R0 and range: write r0=0xFFFFFFFF, then read r0 -> 0. With NUM_REGS=24, write addr 30 then read addr 30 -> 0, rd_busy=0, and no register is modified.
- Scoreboard: set_busy r9, next cycle read r9 -> rd_busy=1. Same cycle: write r9 and set_busy r9 -> busy stays 1. Write r9 alone -> a same-cycle read gives rd_busy=0 (BYPASS=1). set_busy r2 with flush -> r2 not busy.
- Simultaneous events: set_busy r4, write r4=0x55 and read r4 in one cycle (r4 previously not busy) -> rd_data=0x55, rd_busy=0; the following read of r4 gives rd_busy=1.
